draw_scheduler: RTL
===================

Name: draw_scheduler

Overview:
- Sequences the fill-screen engine and the circle engine to draw one frame: a full-screen clear, then NUM_CIRCLES concentric circles with a stepped radius and cycling colour.
- Owns the single VGA plot port and multiplexes it between the two engines.
- Sits between the top-level board wrapper and the fillscreen/circle engines.
- Runs automatically after reset, and again on each restart pulse.

Parameters:
- NUM_CIRCLES, 4, number of circles drawn after the clear (1..15).
- CENTRE_X, 80, circle centre x (8-bit).
- CENTRE_Y, 60, circle centre y (7-bit).
- R_START, 10, radius of first circle (8-bit).
- R_STEP, 10, radius increment per circle (8-bit).
- CLEAR_COLOUR, 3'b000, colour passed to the fill engine.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst_n  in  1  synchronous active-low reset (KEY[3] at top level)
- restart  in  1  single-cycle pulse; restarts the sequence from CLEAR when in DONE
- fill_start  out  1  start to fill engine
- fill_colour  out  3  = CLEAR_COLOUR
- fill_done  in  1  fill engine done
- fill_x/fill_y/fill_colour_px/fill_plot  in  8/7/3/1  fill engine VGA outputs
- circ_start  out  1  start to circle engine
- circ_cx/circ_cy/circ_r  out  8/7/8  circle geometry
- circ_colour  out  3  circle colour
- circ_done  in  1  circle engine done
- circ_x/circ_y/circ_colour_px/circ_plot  in  8/7/3/1  circle engine VGA outputs
- vga_x/vga_y/vga_colour/vga_plot  out  8/7/3/1  muxed VGA port
- busy  out  1  high in CLEAR, CIRCLE or GAP
- done  out  1  high in DONE
- err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- States: CLEAR, CIRCLE, GAP, DONE (registered). rst_n low at a clock edge -> state CLEAR, idx=0, err=0.
- Reset values:
  - Combinational outputs: fill_start=1; circ_start=0; vga_plot=fill_plot gated.
  - Registered outputs: busy=1, done=0. busy/done are registered from the state and are valid the cycle after entry.
- CLEAR:
  - fill_start=1.
  - On fill_done=1 -> GAP with next target CIRCLE, idx=0.
- GAP:
  - Exactly one cycle; fill_start=circ_start=0 so the engines drop done.
  - Then -> CIRCLE, or -> DONE if idx==NUM_CIRCLES.
- CIRCLE:
  - circ_start=1.
  - circ_r = R_START + idx*R_STEP, truncated to 8 bits (wrap permitted, no saturation).
  - circ_colour = (idx mod 7)+1, so colour 0 is never used.
  - circ_cx=CENTRE_X, circ_cy=CENTRE_Y.
  - On circ_done=1 -> idx+1, -> GAP.
- DONE:
  - All starts 0, vga_plot=0, done=1.
  - restart=1 -> CLEAR, idx=0. restart is ignored in every other state.
- Start handshake: start is held high continuously until the matching done is sampled high. It is deasserted in the same cycle the transition is taken, so the engine sees start low for at least the GAP cycle.
- VGA mux is combinational, zero latency:
  - In CLEAR, vga_* = fill_* and vga_plot = fill_plot & fill_start.
  - In CIRCLE, vga_* = circ_* and vga_plot = circ_plot & circ_start.
  - In GAP and DONE, vga_plot=0 and vga_x/y/colour hold the last muxed values.
- Simultaneous events:
  - A done from the inactive engine is ignored.
  - rst_n has priority over restart and over any done.
- Reset mid-operation: the next edge forces CLEAR with fill_start=1. Engines are reset by the same rst_n.
- NUM_CIRCLES=0 is illegal; the bench does not test it.

Optional Feature:
- Macro DRAW_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counter clears on every state entry and increments each cycle in CLEAR/CIRCLE.
  - If it reaches 16'hFFFF before done, the scheduler sets err=1 (sticky until reset), drops the start and goes to GAP as if done had been seen.
- When undefined: no counter, err tied to 0, and the scheduler waits indefinitely.

Test Plan:
- Reset held 2 cycles, released -> state CLEAR, fill_start=1, circ_start=0, busy=1, done=0, vga_plot follows fill_plot.
- Fill model asserts fill_done after 19200 cycles -> next cycle GAP with fill_start=0, vga_plot=0; following cycle CIRCLE, circ_start=1, circ_r=10, circ_colour=1.
- Circle model completes each circle in 50 cycles -> circ_r sequence 10,20,30,40, colours 1,2,3,4; after the 4th circle_done -> GAP then DONE, done=1, vga_plot=0.
- In DONE, pulse restart -> CLEAR with fill_start=1. Pulse restart during CIRCLE -> no effect.
- Assert rst_n=0 for one cycle during circle idx=2 -> CLEAR, idx=0, err=0, circ_start=0.
- With DRAW_SCHED_TIMEOUT_EN defined and circ_done stuck low -> after 65535 cycles in CIRCLE, err=1, scheduler advances to the next circle. Without the macro, it remains in CIRCLE and err=0.

Source files
------------

// File: rtl/draw_scheduler.sv
// draw_scheduler: full-screen clear, then NUM_CIRCLES concentric circles.
// Define DRAW_SCHED_TIMEOUT_EN to add a per-state watchdog driving err.
module draw_scheduler #(
  parameter int unsigned NUM_CIRCLES  = 4,
  parameter logic [7:0]  CENTRE_X     = 8'd80,
  parameter logic [6:0]  CENTRE_Y     = 7'd60,
  parameter logic [7:0]  R_START      = 8'd10,
  parameter logic [7:0]  R_STEP       = 8'd10,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  output logic       fill_start,
  output logic [2:0] fill_colour,
  input  logic       fill_done,
  input  logic [7:0] fill_x,
  input  logic [6:0] fill_y,
  input  logic [2:0] fill_colour_px,
  input  logic       fill_plot,
  output logic       circ_start,
  output logic [7:0] circ_cx,
  output logic [6:0] circ_cy,
  output logic [7:0] circ_r,
  output logic [2:0] circ_colour,
  input  logic       circ_done,
  input  logic [7:0] circ_x,
  input  logic [6:0] circ_y,
  input  logic [2:0] circ_colour_px,
  input  logic       circ_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_CIRCLE,
    S_GAP,
    S_DONE
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic       in_clear;
  logic       in_circ;
  logic       fire_clear;
  logic       fire_circ;
  logic       tmo;
  logic       adv;
  logic [7:0] hold_x;
  logic [6:0] hold_y;
  logic [2:0] hold_c;

  assign in_clear   = (state == S_CLEAR);
  assign in_circ    = (state == S_CIRCLE);
  assign fire_clear = in_clear & fill_done;
  assign fire_circ  = in_circ & circ_done;
  assign adv        = fire_clear | fire_circ | tmo;

  assign fill_start  = in_clear;
  assign fill_colour = CLEAR_COLOUR;
  assign circ_start  = in_circ;
  assign circ_cx     = CENTRE_X;
  assign circ_cy     = CENTRE_Y;
  assign circ_r      = R_START + 8'(idx) * R_STEP;
  assign circ_colour = 3'(idx % 4'd7) + 3'd1;

`ifdef DRAW_SCHED_TIMEOUT_EN
  logic [15:0] wdog;

  assign tmo = (in_clear | in_circ) & (wdog == 16'hFFFF)
             & ~(fire_clear | fire_circ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      if (!(in_clear | in_circ) || adv)
        wdog <= '0;
      else
        wdog <= wdog + 16'd1;
      if (tmo)
        err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Outside CLEAR/CIRCLE the port keeps showing the last muxed pixel
  always_comb begin
    vga_x      = hold_x;
    vga_y      = hold_y;
    vga_colour = hold_c;
    vga_plot   = 1'b0;
    unique case (1'b1)
      in_clear: begin
        vga_x      = fill_x;
        vga_y      = fill_y;
        vga_colour = fill_colour_px;
        vga_plot   = fill_plot & fill_start;
      end
      in_circ: begin
        vga_x      = circ_x;
        vga_y      = circ_y;
        vga_colour = circ_colour_px;
        vga_plot   = circ_plot & circ_start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_CLEAR;
      idx    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      hold_x <= '0;
      hold_y <= '0;
      hold_c <= '0;
    end else begin
      busy <= (state != S_DONE);
      done <= (state == S_DONE);
      if (in_clear | in_circ) begin
        hold_x <= vga_x;
        hold_y <= vga_y;
        hold_c <= vga_colour;
      end
      unique case (state)
        S_CLEAR: begin
          if (adv) begin
            state <= S_GAP;
            idx   <= '0;
          end
        end
        S_CIRCLE: begin
          if (adv) begin
            state <= S_GAP;
            idx   <= idx + 4'd1;
          end
        end
        S_GAP: begin
          if (idx == 4'(NUM_CIRCLES))
            state <= S_DONE;
          else
            state <= S_CIRCLE;
        end
        S_DONE: begin
          if (restart) begin
            state <= S_CLEAR;
            idx   <= '0;
          end
        end
      endcase
    end
  end

endmodule
